// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and iteration constants for the mul/div unit
package muldiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
//
// Ports:
//   is_div   in  1   1 = restoring divide step, 0 = shift-add multiply step
//   acc      in  64  MUL: {partial high, multiplier bits}; DIV: {remainder, dividend/quotient bits}
//   opnd     in  32  MUL: multiplicand magnitude; DIV: divisor magnitude
//   acc_next out 64  accumulator after this iteration
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_next
);

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current LSB is set,
        // then shift the whole 65-bit {carry, acc} right by one.
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // Remainder < divisor, so the shifted value fits in 33 bits and a clear
        // bit 32 of the trial means the subtraction did not borrow.
        div_shift = {acc[63:32], acc[31]};
        div_trial = div_shift - {1'b0, opnd};

        if (is_div) begin
            if (!div_trial[32]) begin
                acc_next = {div_trial[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {div_shift[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/mul_div_ctrl.sv
// rtl/mul_div_ctrl.sv - iterative MIPS-style HI/LO multiply/divide unit with cancel
//
// Ports:
//   clk     in  1   rising-edge clock
//   rst     in  1   asynchronous active-high reset
//   start   in  1   exe-stage request, qualified by op
//   op      in  3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a   in  32  multiplicand / dividend / MTHI-MTLO data
//   src_b   in  32  multiplier / divisor
//   cancel  in  1   pipeline flush; aborts any in-flight operation
//   busy    out 1   stall request to the hazard unit
//   done    out 1   one-cycle pulse in the cycle HI/LO are committed
//   hi      out 32  architectural HI
//   lo      out 32  architectural LO
module mul_div_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [63:0]        acc;
    logic [63:0]        acc_step;
    logic [31:0]        opnd;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               req_ok;
    logic               accept_mul;
    logic               accept_div;
    logic               wr_hi;
    logic               wr_lo;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [63:0]        prod_fix;
    logic [31:0]        quo_fix;
    logic [31:0]        rem_fix;

    muldiv_step u_step (
        .is_div   (op_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    // Request decode and operand magnitudes. 0x80000000 negates to itself,
    // which is the intended modulo-2^32 magnitude for the most-negative value.
    always_comb begin
        req_ok     = (state == ST_IDLE) && start && !cancel;
        accept_mul = req_ok && ((op == OP_MULT) || (op == OP_MULTU));
        accept_div = req_ok && ((op == OP_DIV)  || (op == OP_DIVU));
        wr_hi      = req_ok && (op == OP_MTHI);
        wr_lo      = req_ok && (op == OP_MTLO);
        op_signed  = (op == OP_MULT) || (op == OP_DIV);
        a_neg      = op_signed && src_a[31];
        b_neg      = op_signed && src_b[31];
        a_mag      = cond_neg32(src_a, a_neg);
        b_mag      = cond_neg32(src_b, b_neg);
    end

    // Sign correction applied in FIN.
    always_comb begin
        prod_fix = neg_res ? (~acc + 64'd1) : acc;
        quo_fix  = cond_neg32(acc[31:0], neg_res);
        rem_fix  = cond_neg32(acc[63:32], neg_rem);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = accept_mul || accept_div;
                if (accept_mul) begin
                    state_next = ST_MUL;
                end else if (accept_div) begin
                    state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (count == '0) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                done       = !cancel;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // State is already forced to IDLE, but a start seen during reset must not stall.
        if (rst) begin
            busy = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_mul || accept_div) begin
                        count    <= CNT_INIT;
                        op_div   <= accept_div;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= accept_div && (src_b == 32'd0);
                        opnd     <= accept_div ? b_mag : a_mag;
                        acc      <= {32'd0, (accept_div ? a_mag : b_mag)};
                    end else if (wr_hi) begin
                        hi <= src_a;
                    end else if (wr_lo) begin
                        lo <= src_a;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (!cancel) begin
                        acc   <= acc_step;
                        count <= count - 1'b1;
                    end
                end
                ST_FIN: begin
                    if (!cancel) begin
                        if (op_div) begin
                            // Divide by zero leaves the dividend in the remainder,
                            // so HI already equals src_a; only LO needs forcing.
                            lo <= div_zero ? 32'hFFFF_FFFF : quo_fix;
                            hi <= rem_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// tb/tb_mul_div_ctrl.sv - scoreboard bench for mul_div_ctrl
module tb_mul_div_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    mul_div_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [31:0]        q;
        logic [31:0]        r;
        if (o == OP_MULT) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
        end
        if (o == OP_MULTU) begin
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        if (o == OP_DIVU) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // kind: 0 run to completion, 1 cancel in abort_cyc, 2 rst in abort_cyc.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int kind, input int abort_cyc,
                          input int glitch_cyc);
        logic [63:0] e;
        int          busy_n;
        int          done_at;
        int          busy_late;
        e = (kind == 0) ? model(o, a, b) : (kind == 1) ? {m_hi, m_lo} : 64'd0;
        exp_q.push_back(e);
        start = 1'b1; op = o; src_a = a; src_b = b;
        busy_n = 0; done_at = -1; busy_late = 0;
        for (int c = 0; c < 40; c++) begin
            if (kind == 1 && c == abort_cyc) cancel = 1'b1;
            if (kind == 2 && c == abort_cyc) rst = 1'b1;
            if (c == glitch_cyc) begin
                start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF;
            end
            #2;
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = c;
            if (kind != 0 && c > abort_cyc && busy) busy_late++;
            @(posedge clk); #1;
            start = 1'b0; cancel = 1'b0; rst = 1'b0;
            src_a = $urandom; src_b = $urandom; op = 3'($urandom_range(0, 7));
            if (done_at >= 0) break;
        end
        e = exp_q.pop_front();
        if (kind == 0) begin
            check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
            check({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        end else begin
            check({tag, "_done_seen"}, 64'(done_at >= 0), 64'd0);
            check({tag, "_busy_cycles"}, 64'(busy_n), 64'(kind == 1 ? abort_cyc + 1 : abort_cyc));
            check({tag, "_busy_late"}, 64'(busy_late), 64'd0);
        end
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
        logic [63:0] e;
        e = (o == OP_MTHI) ? {a, m_lo} : {m_hi, a};
        exp_q.push_back(e);
        start = 1'b1; op = o; src_a = a;
        #2;
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #2;
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        e = exp_q.pop_front();
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
        m_hi = e[63:32];
        m_lo = e[31:0];
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = OP_MULT; cancel = 1'b0;
        src_a = 32'h1234_5678; src_b = 32'h0000_0003;
        #3;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_mt("mthi", OP_MTHI, 32'h1234_5678);
        run_mt("mtlo", OP_MTLO, 32'h0BAD_F00D);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, -1);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0, -1, -1);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, -1, 15);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, -1);
        run_op("divu_zero", OP_DIVU, 32'h0000_0064, 32'h0000_0000, 0, -1, -1);
        run_op("div_zero", OP_DIV, 32'hFFFF_FFF0, 32'h0000_0000, 0, -1, -1);
        run_op("mult_mixed", OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, -1, -1);

        // cancel and start together in IDLE: nothing happens
        start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7; cancel = 1'b1;
        #2;
        check("idle_cancel_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        #2;
        check("idle_cancel_busy_next", {63'd0, busy}, 64'd0);
        check("idle_cancel_hi", {32'd0, hi}, {32'd0, m_hi});
        check("idle_cancel_lo", {32'd0, lo}, {32'd0, m_lo});
        @(posedge clk); #1;

        run_op("divu_cancel", OP_DIVU, 32'h0000_1000, 32'h0000_0003, 1, 10, -1);
        run_op("mult_rst", OP_MULT, 32'h0000_1234, 32'h0000_5678, 2, 5, -1);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), ro, ra, rb, 0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_div_ctrl.md
MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, listed first: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-002 start in 1: exe-stage request, qualified by op.
REQ-003 op in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 are no-ops.
REQ-004 src_a in 32: multiplicand, dividend, or MTHI/MTLO data.
REQ-005 src_b in 32: multiplier or divisor.
REQ-006 cancel in 1: pipeline flush from exception or branch; aborts any in-flight operation.
REQ-007 busy out 1: drives the hazard unit's exe_busy and stalls all stages.
REQ-008 done out 1: single-cycle pulse in the cycle the result is committed.
REQ-009 hi out 32: architectural HI register value.
REQ-010 lo out 32: architectural LO register value.

Function
REQ-011 FSM states SHALL be IDLE, MUL, DIV and FIN.
REQ-012 IDLE: start with op 0-1 SHALL load operand magnitudes and signs, set count=31 and go to MUL; op 2-3 SHALL do the same and go to DIV.
REQ-013 IDLE, start with op 4/5: HI/LO SHALL be written with src_a at that edge; busy SHALL stay 0; done SHALL stay 0.
REQ-014 busy SHALL be combinational: (state==MUL or DIV) OR (state==IDLE AND start AND op<=3 AND NOT cancel).
REQ-015 MUL SHALL perform one radix-2 shift-add step per cycle on the 64-bit partial product.
REQ-016 DIV SHALL perform one radix-2 restoring step per cycle on the 32-bit remainder and quotient.
REQ-017 In MUL and DIV, count SHALL decrement each cycle; the count==0 step SHALL transition to FIN.
REQ-018 FIN SHALL apply sign correction and write HI/LO at its closing edge, assert done, deassert busy, and return to IDLE.
REQ-019 Latency: start in cycle 0 -> busy high in cycles 0..32 -> FIN and done in cycle 33 -> new hi/lo visible in cycle 34.
REQ-020 Signed multiply SHALL negate the 64-bit product iff operand signs differ.
REQ-021 Signed divide SHALL negate the quotient iff operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero (signed or unsigned) SHALL give LO=0xFFFFFFFF and HI=src_a.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0, with magnitude arithmetic modulo 2^32.
REQ-024 MULT/MULTU SHALL write HI=product[63:32] and LO=product[31:0]; DIV/DIVU SHALL write LO=quotient and HI=remainder.
REQ-025 start SHALL be ignored outside IDLE, including in FIN.
REQ-026 cancel in MUL/DIV/FIN SHALL move to IDLE at the next edge with HI/LO unchanged, done=0, and busy=0 from the next cycle.
REQ-027 cancel and start together in IDLE: cancel SHALL win; no state change and no HI/LO write.
REQ-028 Operand registers SHALL hold latched values; src_a/src_b changes after acceptance SHALL have no effect.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, count=0, hi=0, lo=0, done=0 and all operand/partial registers to 0.
REQ-030 With rst high, busy SHALL be 0.
REQ-031 rst asserted mid-operation SHALL discard the operation; HI/LO SHALL read 0 after reset.

Structure
REQ-032 A shared package muldiv_pkg SHALL hold the op encodings, the FSM state encoding and the constant ITER=32.
REQ-033 One combinational sub-module muldiv_step SHALL compute one iteration, selected by a mul/div flag: shift-add for MUL, trial-subtract/restore for DIV.
REQ-034 All state SHALL be held in mul_div_ctrl.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high exactly 33 cycles, done in cycle 33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-037 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 DIVU 0x00000064 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, latency 33 cycles.
REQ-039 MTHI 0x12345678 -> HI=0x12345678 next cycle, busy never high; a start pulse during a later DIV -> ignored.
REQ-040 DIVU started then cancel in cycle 10 -> busy low from cycle 11, no done, HI/LO keep prior values; rst pulse in cycle 5 of MULT -> HI=LO=0, state IDLE.
